boton_eventos: RTL and testbench
================================

Name: boton_eventos

Overview:
- Consumes the clean, debounced button level produced by the debouncer and converts it into single-cycle event pulses for the control FSMs.
- Event pulses: press, release, short press, long press, and auto-repeat while held.
- Runs in the 20 MHz system clock domain.
- The input is already synchronised and debounced, so no further filtering is done here.

Parameters:
- LONG_COUNT, 20_000_000, hold cycles after press_pulse before long_pulse (1 s at 20 MHz); legal range 2 .. 2^CNT_W-1.
- REPEAT_COUNT, 4_000_000, cycles between repeat_pulse events while in long hold (200 ms); legal range 2 .. 2^CNT_W-1.
- CNT_W, 25, hold/repeat counter width; must satisfy 2^CNT_W > max(LONG_COUNT, REPEAT_COUNT).

Ports:
- clk  input  1  system clock, 20 MHz.
- rst  input  1  synchronous reset, active-high.
- btn_in  input  1  debounced button level, 1 = pressed; synchronous to clk.
- repeat_en  input  1  1 = generate repeat_pulse during long hold; sampled every cycle.
- press_pulse  output  1  one-cycle pulse on press.
- release_pulse  output  1  one-cycle pulse on any release.
- short_pulse  output  1  one-cycle pulse on release before long threshold.
- long_pulse  output  1  one-cycle pulse when hold reaches LONG_COUNT.
- repeat_pulse  output  1  one-cycle pulse every REPEAT_COUNT cycles in long hold.
- held  output  1  level, 1 while the FSM considers the button pressed.

Behaviour:
- All outputs are registered.
- Reset (rst=1 at a clk edge):
  - state <= IDLE, counter <= 0, all pulse outputs and held <= 0.
  - btn_prev <= 1, so a button held through reset produces no press; a press requires btn_in to be seen low first.
- btn_prev <= btn_in every non-reset cycle.
- Rising edge = btn_in=1 and btn_prev=0.
- Pulse outputs default to 0 every cycle; each pulse lasts exactly one cycle.
- FSM states: IDLE, PRESSED, LONG_HELD.
- IDLE:
  - On rising edge: press_pulse<=1, held<=1, counter<=0, go to PRESSED.
  - Latency: press_pulse is high in the cycle after the first clk edge that samples btn_in=1.
- PRESSED:
  - If btn_in=0: release_pulse<=1, short_pulse<=1, held<=0, go to IDLE.
  - Else if counter == LONG_COUNT-1: long_pulse<=1, counter<=0, go to LONG_HELD.
  - Else: counter<=counter+1.
  - long_pulse therefore follows press_pulse by exactly LONG_COUNT cycles.
- LONG_HELD:
  - If btn_in=0: release_pulse<=1, held<=0, counter<=0, go to IDLE. No short_pulse.
  - Else if repeat_en=0: counter<=0, no pulses.
  - Else if counter == REPEAT_COUNT-1: repeat_pulse<=1, counter<=0.
  - Else: counter<=counter+1.
  - With repeat_en held at 1, the first repeat_pulse comes REPEAT_COUNT cycles after long_pulse, then every REPEAT_COUNT cycles.
- Simultaneous events:
  - Release in the same cycle the long threshold would fire: release wins. Outputs are short_pulse + release_pulse; long_pulse is not generated.
  - Release in the same cycle repeat would fire: release wins; repeat_pulse is not generated.
  - repeat_en falling mid-count clears the counter. On re-enable, counting restarts from 0.
- A single press never produces more than one of short_pulse / long_pulse.
- No two of press/release pulses occur in the same cycle.
- The counter never exceeds max(LONG_COUNT, REPEAT_COUNT)-1; no wrap-around is possible.
- Reset mid-press forces IDLE with all outputs 0 on the next cycle. A still-held button is ignored until released.
- A one-cycle btn_in high pulse is legal: press_pulse, then short_pulse + release_pulse on the following cycle.

Test Plan (LONG_COUNT=10, REPEAT_COUNT=4):
1. btn_in 0→1 for 5 cycles then 0 -> press_pulse 1 cycle after rise; short_pulse and release_pulse together 1 cycle after fall; no long_pulse; held high 5 cycles.
2. btn_in high for 30 cycles, repeat_en=1 -> press_pulse at cycle t; long_pulse at t+10; repeat_pulse at t+14, t+18, t+22, t+26; release_pulse only on release (short_pulse stays 0).
3. Same as 2 with repeat_en=0 -> long_pulse at t+10, zero repeat_pulses. Toggle repeat_en to 1 at t+15 -> first repeat_pulse 4 cycles later.
4. btn_in released exactly on the cycle counter==9 -> short_pulse + release_pulse; long_pulse never asserted.
5. btn_in=1 across rst deassertion, held 20 cycles -> no pulses and held=0. Then btn_in 0 for 2 cycles, then 1 -> normal press_pulse.
6. rst asserted one cycle while in LONG_HELD -> next cycle all outputs 0, state IDLE; no release_pulse when btn_in later falls.

Source files
------------

// File: rtl/boton_eventos_if.sv
// boton_eventos_if: debounced button level in, single-cycle button events out
interface boton_eventos_if;
  logic btn_in;
  logic repeat_en;
  logic press_pulse;
  logic release_pulse;
  logic short_pulse;
  logic long_pulse;
  logic repeat_pulse;
  logic held;
  modport master (
    output btn_in, repeat_en,
    input  press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, held
  );
  modport slave (
    input  btn_in, repeat_en,
    output press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, held
  );
endinterface

// File: rtl/boton_eventos.sv
// boton_eventos: turns a debounced button level into press/release/short/long/repeat pulses
module boton_eventos #(
  parameter int LONG_COUNT   = 20_000_000,
  parameter int REPEAT_COUNT = 4_000_000,
  parameter int CNT_W        = 25
) (
  input logic           clk,
  input logic           rst,
  boton_eventos_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PRESSED, LONG_HELD} state_t;
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_COUNT - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_COUNT - 1);
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             btn_prev_q;
  logic             press_q, release_q, short_q, long_q, repeat_q, held_q;
  // btn_prev resets high so a button held through reset must be released before it counts
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      btn_prev_q <= 1'b1;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      short_q    <= 1'b0;
      long_q     <= 1'b0;
      repeat_q   <= 1'b0;
      held_q     <= 1'b0;
    end else begin
      btn_prev_q <= bus.btn_in;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      short_q    <= 1'b0;
      long_q     <= 1'b0;
      repeat_q   <= 1'b0;
      case (state_q)
        IDLE: if (bus.btn_in && !btn_prev_q) begin
          press_q <= 1'b1;
          held_q  <= 1'b1;
          cnt_q   <= '0;
          state_q <= PRESSED;
        end
        PRESSED: if (!bus.btn_in) begin
          release_q <= 1'b1;
          short_q   <= 1'b1;
          held_q    <= 1'b0;
          state_q   <= IDLE;
        end else if (cnt_q == LONG_LAST) begin
          long_q  <= 1'b1;
          cnt_q   <= '0;
          state_q <= LONG_HELD;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        LONG_HELD: if (!bus.btn_in) begin
          release_q <= 1'b1;
          held_q    <= 1'b0;
          cnt_q     <= '0;
          state_q   <= IDLE;
        end else if (!bus.repeat_en) begin
          cnt_q <= '0;
        end else if (cnt_q == REP_LAST) begin
          repeat_q <= 1'b1;
          cnt_q    <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        default: begin
          state_q <= IDLE;
          held_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.short_pulse   = short_q;
  assign bus.long_pulse    = long_q;
  assign bus.repeat_pulse  = repeat_q;
  assign bus.held          = held_q;
endmodule

// File: tb/tb_boton_eventos.sv
// tb_boton_eventos: scoreboard bench comparing every output cycle against a hold-time model
module tb_boton_eventos;
  localparam int LONG = 10;
  localparam int REP  = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic [5:0] exp_q[$];
  boton_eventos_if bus();
  boton_eventos #(.LONG_COUNT(LONG), .REPEAT_COUNT(REP), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  // model: tracks time since press and time since long/repeat, in edges
  logic m_prev = 1'b1;
  bit   m_act = 0, m_long = 0;
  int   el = 0, rc = 0;
  logic [5:0] e;
  always @(posedge clk) begin
    e = '0;
    cyc++;
    if (rst) begin
      m_prev = 1'b1;
      m_act  = 0;
      m_long = 0;
    end else begin
      if (!m_act) begin
        if (bus.btn_in && !m_prev) begin
          e[5] = 1'b1; m_act = 1; m_long = 0; el = 0;
        end
      end else if (!bus.btn_in) begin
        e[4] = 1'b1; e[3] = !m_long; m_act = 0;
      end else if (!m_long) begin
        el++;
        if (el == LONG) begin e[2] = 1'b1; m_long = 1; rc = 0; end
      end else if (!bus.repeat_en) begin
        rc = 0;
      end else begin
        rc++;
        if (rc == REP) begin e[1] = 1'b1; rc = 0; end
      end
      m_prev = bus.btn_in;
    end
    e[0] = m_act;
    exp_q.push_back(e);
  end
  logic [5:0] act, want;
  always @(negedge clk) if (exp_q.size() > 0) begin
    want = exp_q.pop_front();
    act  = {bus.press_pulse, bus.release_pulse, bus.short_pulse,
            bus.long_pulse, bus.repeat_pulse, bus.held};
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL outputs cycle %0d {press,rel,short,long,rep,held}: got %b expected %b", cyc, act, want);
    end
  end
  task automatic step(input logic b, input logic en, input logic r, input int n);
    for (int i = 0; i < n; i++) begin
      bus.btn_in = b; bus.repeat_en = en; rst = r;
      @(posedge clk); #1;
    end
  endtask
  initial begin
    bus.btn_in = 1'b0; bus.repeat_en = 1'b0;
    step(0, 0, 1, 2);
    step(0, 0, 0, 2);
    step(1, 0, 0, 5);  step(0, 0, 0, 3);
    step(1, 1, 0, 30); step(0, 1, 0, 3);
    step(1, 0, 0, 15); step(1, 1, 0, 15); step(0, 0, 0, 3);
    step(1, 1, 0, 10); step(0, 1, 0, 3);
    step(1, 1, 0, 11); step(0, 1, 0, 3);
    step(1, 1, 0, 18); step(1, 1, 1, 1); step(1, 1, 0, 20);
    step(0, 0, 0, 2);  step(1, 0, 0, 3);  step(0, 0, 0, 2);
    step(1, 1, 0, 16); step(1, 1, 1, 1);  step(1, 1, 0, 4); step(0, 1, 0, 3);
    step(1, 0, 0, 1);  step(0, 0, 0, 3);
    for (int k = 0; k < 60; k++) begin
      int hi;
      hi = $urandom_range(1, 30);
      step(0, 1'($urandom), 0, $urandom_range(1, 4));
      for (int j = 0; j < hi; j++)
        step(1, ($urandom_range(0, 3) != 0), ($urandom_range(0, 60) == 0), 1);
    end
    step(0, 0, 0, 4);
    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
